// File: rtl/adder_tree_sched.sv
// Round-robin scheduler feeding one shared pipelined 16-lane adder tree.
// Results return tagged with the requester ID via a latency-matched tag pipe.
module adder_tree_sched #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int LANES    = 16,
  parameter int IN_W     = 8,
  parameter int SUM_W    = 16,
  parameter int TREE_LAT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*LANES*IN_W-1:0] req_data,
  output logic [LANES*IN_W-1:0]         tree_inp,
  input  logic [SUM_W-1:0]              tree_sum,
  output logic                          res_valid,
  output logic [ID_W-1:0]               res_id,
  output logic [SUM_W-1:0]              res_sum,
  output logic                          busy,
  output logic                          idle,
  output logic [15:0]                   issued_cnt
);

  localparam int VEC_W = LANES * IN_W;
  localparam int DEPTH = TREE_LAT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [VEC_W-1:0]    tree_inp_q, tree_inp_d;
  logic [15:0]         issued_cnt_q, issued_cnt_d;
  logic [DEPTH-1:0]    tag_v_q, tag_v_d;
  logic [ID_W-1:0]     tag_id_q [DEPTH];
  logic [ID_W-1:0]     tag_id_d [DEPTH];

  logic [VEC_W-1:0]    req_vec [NUM_REQ];
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     win_id;
  logic                found;
  logic [NUM_REQ-1:0]  grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign req_vec[g] = req_data[g*VEC_W +: VEC_W];
  end

  // Search begins one past the last winner, so a held request waits at most NUM_REQ cycles.
  always_comb begin
    cand   = '0;
    win_id = '0;
    found  = 1'b0;
    grant  = '0;
    if (state_q == S_RUN && en) begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = ID_W'((32'(rr_q) + i) % NUM_REQ);
        if (!found && req_valid[cand]) begin
          found  = 1'b1;
          win_id = cand;
        end
      end
    end
    if (found) grant = NUM_REQ'(1) << win_id;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (!en) state_d = busy ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d         = rr_q;
    tree_inp_d   = tree_inp_q;
    issued_cnt_d = issued_cnt_q;
    tag_v_d      = {tag_v_q[DEPTH-2:0], found};
    tag_id_d[0]  = win_id;
    for (int unsigned i = 1; i < DEPTH; i++) tag_id_d[i] = tag_id_q[i-1];
    if (found) begin
      rr_d         = win_id;
      tree_inp_d   = req_vec[win_id];
      issued_cnt_d = issued_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= ID_W'(NUM_REQ - 1);
      tree_inp_q   <= '0;
      issued_cnt_q <= '0;
      tag_v_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      tree_inp_q   <= tree_inp_d;
      issued_cnt_q <= issued_cnt_d;
      tag_v_q      <= tag_v_d;
      for (int unsigned i = 0; i < DEPTH; i++) tag_id_q[i] <= tag_id_d[i];
    end
  end

  assign req_ready  = grant;
  assign tree_inp   = tree_inp_q;
  assign res_valid  = tag_v_q[DEPTH-1];
  assign res_id     = tag_id_q[DEPTH-1];
  assign res_sum    = tree_sum;
  assign busy       = |tag_v_q;
  assign idle       = (state_q == S_IDLE);
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with a 4-stage behavioural adder tree.
module tb_adder_tree_sched;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int LANES    = 16;
  localparam int IN_W     = 8;
  localparam int SUM_W    = 16;
  localparam int TREE_LAT = 4;

  logic         clk = 1'b0;
  logic         reset, en;
  logic [3:0]   req_valid, req_ready;
  logic [511:0] req_data;
  logic [127:0] tree_inp;
  logic [15:0]  tree_sum, res_sum, issued_cnt;
  logic         res_valid, busy, idle;
  logic [1:0]   res_id;
  logic [15:0]  s1, s2, s3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adder_tree_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LANES(LANES), .IN_W(IN_W),
                     .SUM_W(SUM_W), .TREE_LAT(TREE_LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .tree_inp(tree_inp), .tree_sum(tree_sum), .res_valid(res_valid),
    .res_id(res_id), .res_sum(res_sum), .busy(busy), .idle(idle), .issued_cnt(issued_cnt)
  );

  function automatic logic [15:0] lane_sum(input logic [127:0] v);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < 16; j++) s = s + 16'(v[8*j +: 8]);
    return s;
  endfunction

  // Tree model: four register stages from tree_inp to tree_sum.
  always @(posedge clk) begin
    s1       <= lane_sum(tree_inp);
    s2       <= s1;
    s3       <= s2;
    tree_sum <= s3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%0b exp=0000", req_ready); end
    total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", issued_cnt); end
    total++; if (tree_inp !== 128'd0) begin bad++; $display("FAIL reset_tree_inp got=%0h exp=0", tree_inp); end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; req_valid = 4'b0001; req_data[127:0] = {16{8'h01}};
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_idle_ready got=%0b exp=0000", req_ready); end
    tick();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%0b exp=0001", req_ready); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_run_idle got=%0b exp=0", idle); end
    tick();
    req_valid = '0;
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", issued_cnt); end
    total++; if (tree_inp !== {16{8'h01}}) begin bad++; $display("FAIL single_tree_inp got=%0h exp=%0h", tree_inp, {16{8'h01}}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy); end
    for (int n = 2; n <= 7; n++) begin
      if (n > 2) tick();
      total++; if (res_valid !== (n == 6)) begin bad++; $display("FAIL single_res_valid cyc=%0d got=%0b exp=%0b", n, res_valid, n == 6); end
      if (n == 6) begin
        total++; if (res_id !== 2'd0) begin bad++; $display("FAIL single_res_id got=%0d exp=0", res_id); end
        total++; if (res_sum !== 16'd16) begin bad++; $display("FAIL single_res_sum got=%0d exp=16", res_sum); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1; req_valid = 4'b1111; req_data = {64{8'hFF}};
    tick();
    for (int n = 1; n <= 14; n++) begin
      if (n == 9) req_valid = '0;
      #1;
      total++;
      if (req_ready !== (n <= 8 ? 4'(1 << ((n - 1) % 4)) : 4'b0000)) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%0b", n, req_ready);
      end
      total++; if (res_valid !== (n >= 6 && n <= 13)) begin bad++; $display("FAIL rr_res_valid cyc=%0d got=%0b", n, res_valid); end
      if (n >= 6 && n <= 13) begin
        total++; if (res_id !== 2'((n - 6) % 4)) begin bad++; $display("FAIL rr_res_id cyc=%0d got=%0d exp=%0d", n, res_id, (n - 6) % 4); end
        total++; if (res_sum !== 16'd4080) begin bad++; $display("FAIL rr_res_sum cyc=%0d got=%0d exp=4080", n, res_sum); end
      end
      tick();
    end
  endtask

  task automatic test_two_sums();
    logic [127:0] v;
    do_reset();
    for (int j = 0; j < 16; j++) v[8*j +: 8] = 8'(j);
    en = 1'b1; req_valid = 4'b1100;
    req_data[256 +: 128] = v;
    req_data[384 +: 128] = {16{8'h07}};
    tick();
    for (int n = 1; n <= 9; n++) begin
      if (n == 3) req_valid = '0;
      #1;
      if (n == 1) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL two_grant1 got=%0b exp=0100", req_ready); end
      end
      if (n == 2) begin
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL two_grant2 got=%0b exp=1000", req_ready); end
      end
      total++; if (res_valid !== (n == 6 || n == 7)) begin bad++; $display("FAIL two_res_valid cyc=%0d got=%0b", n, res_valid); end
      if (n == 6) begin
        total++; if (res_id !== 2'd2 || res_sum !== 16'd120) begin bad++; $display("FAIL two_res_a got=id%0d/%0d exp=id2/120", res_id, res_sum); end
      end
      if (n == 7) begin
        total++; if (res_id !== 2'd3 || res_sum !== 16'd112) begin bad++; $display("FAIL two_res_b got=id%0d/%0d exp=id3/112", res_id, res_sum); end
      end
      tick();
    end
  endtask

  task automatic test_drain();
    do_reset();
    en = 1'b1; req_valid = 4'b0001; req_data[127:0] = {16{8'h02}};
    tick();
    for (int n = 1; n <= 10; n++) begin
      if (n == 4) en = 1'b0;
      if (n == 5) en = 1'b1;
      #1;
      total++; if (req_ready !== (n <= 3 ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL drain_ready cyc=%0d got=%0b", n, req_ready); end
      total++; if (busy !== (n >= 2 && n <= 8)) begin bad++; $display("FAIL drain_busy cyc=%0d got=%0b", n, busy); end
      total++; if (idle !== (n == 10)) begin bad++; $display("FAIL drain_idle cyc=%0d got=%0b", n, idle); end
      total++; if (res_valid !== (n >= 6 && n <= 8)) begin bad++; $display("FAIL drain_res_valid cyc=%0d got=%0b", n, res_valid); end
      if (n >= 6 && n <= 8) begin
        total++; if (res_id !== 2'd0 || res_sum !== 16'd32) begin bad++; $display("FAIL drain_res got=id%0d/%0d exp=id0/32", res_id, res_sum); end
      end
      if (n < 10) tick();
    end
    total++; if (issued_cnt !== 16'd3) begin bad++; $display("FAIL drain_cnt got=%0d exp=3", issued_cnt); end
    en = 1'b0; req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; req_valid = 4'b0001; req_data[127:0] = {16{8'h01}};
    tick();
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1; en = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midreset_res_valid cyc=%0d got=%0b exp=0", n, res_valid); end
      if (n == 0) begin
        total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL midreset_cnt got=%0d exp=0", issued_cnt); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL midreset_idle got=%0b exp=1", idle); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; req_valid = 4'b0001; req_data[127:0] = {16{8'h03}};
    tick();
    repeat (65536) tick();
    total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", issued_cnt); end
    tick();
    req_valid = '0;
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL wrap_one got=%0d exp=1", issued_cnt); end
    repeat (6) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%0b exp=0", busy); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_two_sums();
    test_drain();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_tree_sched.md
Name: adder_tree_sched

Overview:
- Round-robin scheduler that shares one pipelined 16-input, 8-bit adder tree (4-cycle latency, 16-bit sum) among NUM_REQ requesters.
- Accepts one operand vector per cycle, registers it onto the tree input bus, and carries a requester-ID tag down a matched-latency pipe.
- Returns each sum with its ID. Includes an enable/drain FSM so software can quiesce the tree.

Parameters:
NUM_REQ, 4, number of requesters
ID_W, 2, requester ID width, clog2(NUM_REQ)
LANES, 16, operand lanes per vector
IN_W, 8, lane width
SUM_W, 16, tree result width
TREE_LAT, 4, clock edges from tree input bus to valid tree_sum

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  scheduling enable
req_valid  in  NUM_REQ  per-requester vector valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_data  in  NUM_REQ*LANES*IN_W  requester i at bits [(i+1)*128-1 : i*128]
tree_inp  out  LANES*IN_W  registered operands; lane j at bits [8j+7:8j] maps to tree pair (j/2, j%2)
tree_sum  in  SUM_W  tree output
res_valid  out  1  result valid, one cycle per issued vector
res_id  out  ID_W  requester ID of result
res_sum  out  SUM_W  equals tree_sum
busy  out  1  any vector in flight
idle  out  1  FSM in IDLE
issued_cnt  out  16  vectors issued, wraps 0xFFFF->0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: FSM=IDLE, rr pointer=NUM_REQ-1 (so req 0 has first priority), tag pipe valids=0, issued_cnt=0, tree_inp=0. Outputs after reset: res_valid=0, busy=0, idle=1, req_ready=0.
- Reset mid-operation: all in-flight tags are dropped, so no res_valid is produced for them. The tree's unreset internal stages therefore never leak results.
- FSM states and transitions:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0 and busy=0; RUN -> DRAIN when en=0 and busy=1.
  - DRAIN -> IDLE when busy=0. en is ignored in DRAIN.
- Grants are issued only in RUN with en=1. req_ready is all-zero in IDLE and DRAIN.
- Grant (combinational):
  - Round-robin search starts at rr pointer+1 mod NUM_REQ; first requester with req_valid=1 wins.
  - req_ready[i]=1 only for the winner. A handshake is req_valid[i]&req_ready[i] at a rising edge.
  - On a handshake, rr pointer <= winner. Otherwise rr pointer holds.
  - A requester holding valid is granted within NUM_REQ cycles (no starvation).
- Issue, at the handshake edge k:
  - tree_inp <= winner's req_data.
  - Tag stage 0 <= {1, winner ID}.
  - issued_cnt += 1.
  - With no handshake, tree_inp holds its value and tag stage 0 valid <= 0.
- Tag pipe:
  - TREE_LAT stages after stage 0, shifting every edge.
  - res_valid/res_id are the final stage, so res_valid is high in the cycle after edge k+TREE_LAT. That is TREE_LAT+1 cycles after the accept cycle, aligned with tree_sum.
- Throughput: one vector per cycle sustained; back-to-back results produce consecutive res_valid cycles.
- res_sum passes tree_sum through unmodified. Maximum value is 16*255=4080, so no overflow in SUM_W.
- No result backpressure: consumers must accept res_valid every cycle.
- busy = OR of all tag-stage valids, including stage 0.
- Simultaneous events:
  - en falling on a handshake edge: the vector is still issued; next state is DRAIN.
  - Requesters deasserting req_valid while not granted is legal.

Test Plan:
- Reset, en=1, req 0 valid with all lanes=1 -> req_ready=0001 in the cycle after en rises; res_valid with res_id=0, res_sum=16 exactly 5 cycles after accept; issued_cnt=1.
- All 4 requesters valid continuously, lanes=255 -> grants in order 0,1,2,3,0,...; res_valid high every cycle after fill; each res_sum=4080 with IDs in grant order.
- Req 2 lanes 0..15 (lane j=j), req 3 lanes all 7, both valid -> sums 120 (ID 2) then 112 (ID 3) on consecutive cycles.
- Drop en after 3 back-to-back issues -> FSM DRAIN, req_ready=0, 3 results still return, then idle=1 and busy=0.
- Assert reset two cycles after an issue -> no res_valid in following 8 cycles, issued_cnt=0, idle=1.
- Issue 65537 vectors -> issued_cnt wraps to 1.
